// File: rtl/serial_link_pkg.sv
// Shared link definitions: FSM state encoding and line levels for the serial transmitter.
package serial_link_pkg;

  localparam int unsigned DATA_BITS   = 8;
  localparam logic        START_LEVEL = 1'b0;
  localparam logic        STOP_LEVEL  = 1'b1;
  localparam logic        IDLE_LEVEL  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

endpackage

// File: rtl/serial_byte_tx_if.sv
// Byte-in / serial-out bundle of serial_byte_tx; the source drives through the master modport.
interface serial_byte_tx_if;

  logic [serial_link_pkg::DATA_BITS-1:0] tx_data;
  logic                                  tx_valid;
  logic                                  tx_ready;
  logic                                  tx_line;
  logic                                  busy;
  logic                                  byte_done;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, tx_line, busy, byte_done
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, tx_line, busy, byte_done
  );

endinterface

// File: rtl/baud_tick_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the terminal count; restart forces 0.
module baud_tick_gen #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  // CLKS_PER_BIT-1 always fits in CNT_W bits, so the cast never truncates.
  localparam logic [CNT_W-1:0] TERM = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;

  assign tick = (cnt_q == TERM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              cnt_q <= '0;
    else if (restart || tick) cnt_q <= '0;
    else                     cnt_q <= cnt_q + CNT_W'(1);
  end

endmodule

// File: rtl/serial_byte_tx.sv
// Byte-serial transmitter: start bit, 8 data bits LSB-first, optional even parity, stop bit.
// Define SERIAL_TX_PARITY_EN to insert the parity bit between data and stop.
module serial_byte_tx
  import serial_link_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  serial_byte_tx_if.slave  bus
);

  localparam int unsigned    IDX_W    = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  tx_state_e              state_q, state_d;
  logic [DATA_BITS-1:0]   sh_q, sh_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   tick, accept;
  logic                   line_d, ready_d, busy_d, done_d;
  logic                   line_q, ready_q, busy_q, done_q;

  assign accept = (state_q == IDLE) && ready_q && bus.tx_valid;

  baud_tick_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (accept),
    .tick    (tick)
  );

`ifdef SERIAL_TX_PARITY_EN
  // Parity is captured at accept because the shift register is consumed during DATA.
  logic par_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      par_q <= 1'b0;
    else if (accept) par_q <= ^bus.tx_data;
  end
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (accept) state_d = START;
      START:  if (tick)   state_d = DATA;
`ifdef SERIAL_TX_PARITY_EN
      DATA:   if (tick && idx_q == IDX_LAST) state_d = PARITY;
      PARITY: if (tick)   state_d = STOP;
`else
      DATA:   if (tick && idx_q == IDX_LAST) state_d = STOP;
`endif
      STOP:   if (tick)   state_d = IDLE;
      default:            state_d = IDLE;
    endcase
  end

  // Shift register and bit index; the index wraps 7 -> 0 on the last data bit.
  always_comb begin
    sh_d  = sh_q;
    idx_d = idx_q;
    if (accept) begin
      sh_d  = bus.tx_data;
      idx_d = '0;
    end else if (state_q == DATA && tick) begin
      sh_d  = {1'b0, sh_q[DATA_BITS-1:1]};
      idx_d = idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q  <= '0;
      idx_q <= '0;
    end else begin
      sh_q  <= sh_d;
      idx_q <= idx_d;
    end
  end

  // Output logic: evaluated on the next state so registered outputs line up with the state.
  always_comb begin
    case (state_d)
      START:   line_d = START_LEVEL;
      DATA:    line_d = sh_d[0];
`ifdef SERIAL_TX_PARITY_EN
      PARITY:  line_d = par_q;
`endif
      STOP:    line_d = STOP_LEVEL;
      default: line_d = IDLE_LEVEL;
    endcase
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
    done_d  = (state_q == STOP) && tick;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_q  <= IDLE_LEVEL;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      line_q  <= line_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.tx_line   = line_q;
  assign bus.tx_ready  = ready_q;
  assign bus.busy      = busy_q;
  assign bus.byte_done = done_q;

endmodule
